// File: rtl/alu_exec_ctrl_pkg.sv
// Shared constants, state encoding and opcode classification for the ALU execute controller.
package alu_exec_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SUM_W  = DATA_W + 1;

  // NZCV bit positions within the flags word
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // ARM data-processing opcodes
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_RSB = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_TEQ = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_CMN = 4'b1011;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_BIC = 4'b1110;

  // ARM condition codes
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_EOR = 3'd1,
    ALU_SUB = 3'd2,
    ALU_RSB = 3'd3,
    ALU_ADD = 3'd4,
    ALU_ORR = 3'd5,
    ALU_BIC = 3'd6
  } alu_sel_e;

  function automatic logic op_supported(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_EOR) || (op == OP_SUB) || (op == OP_RSB) ||
           (op == OP_ADD) || (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) ||
           (op == OP_CMN) || (op == OP_ORR) || (op == OP_BIC);
  endfunction

  function automatic logic op_compare(input logic [3:0] op);
    return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
  endfunction

  function automatic logic op_arith(input logic [3:0] op);
    return (op == OP_SUB) || (op == OP_RSB) || (op == OP_ADD) ||
           (op == OP_CMP) || (op == OP_CMN);
  endfunction

endpackage

// File: rtl/arm_alu.sv
// Combinational ARM-style ALU producing a result and NZCV; C on subtraction is not-borrow.
module arm_alu
  import alu_exec_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_sel_e          sel,
  output logic [DATA_W-1:0] result,
  output logic              n,
  output logic              z,
  output logic              c,
  output logic              v
);

  logic [SUM_W-1:0] sum;

  // Operation select; subtraction is done as x + ~y + 1 so the carry out is not-borrow
  always_comb begin
    sum    = '0;
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (sel)
      ALU_AND: result = a & b;
      ALU_EOR: result = a ^ b;
      ALU_ORR: result = a | b;
      ALU_BIC: result = a & ~b;
      ALU_SUB: begin
        sum    = {1'b0, a} + {1'b0, ~b} + SUM_W'(1);
        result = sum[DATA_W-1:0];
        c      = sum[DATA_W];
        v      = (a[DATA_W-1] ^ b[DATA_W-1]) & (result[DATA_W-1] ^ a[DATA_W-1]);
      end
      ALU_RSB: begin
        sum    = {1'b0, b} + {1'b0, ~a} + SUM_W'(1);
        result = sum[DATA_W-1:0];
        c      = sum[DATA_W];
        v      = (b[DATA_W-1] ^ a[DATA_W-1]) & (result[DATA_W-1] ^ b[DATA_W-1]);
      end
      ALU_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[DATA_W-1:0];
        c      = sum[DATA_W];
        v      = ~(a[DATA_W-1] ^ b[DATA_W-1]) & (result[DATA_W-1] ^ a[DATA_W-1]);
      end
      default: result = '0;
    endcase
    n = result[DATA_W-1];
    z = (result == '0);
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Single-issue execute controller: latches a request, evaluates the condition, runs the ALU, writes back.
module alu_exec_ctrl
  import alu_exec_ctrl_pkg::*;
#(
  parameter int unsigned RD_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_cond,
  input  logic [3:0]        req_opcode,
  input  logic              req_s,
  input  logic [RD_W-1:0]   req_rd,
  input  logic [DATA_W-1:0] req_op1,
  input  logic [DATA_W-1:0] req_op2,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [3:0]        flags,
  output logic              retire,
  output logic              retire_skip,
  output logic              retire_undef
);

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic fn, fz, fc, fv;
    fn = f[FLAG_N];
    fz = f[FLAG_Z];
    fc = f[FLAG_C];
    fv = f[FLAG_V];
    case (cond)
      COND_EQ: return fz;
      COND_NE: return !fz;
      COND_CS: return fc;
      COND_CC: return !fc;
      COND_MI: return fn;
      COND_PL: return !fn;
      COND_VS: return fv;
      COND_VC: return !fv;
      COND_HI: return fc && !fz;
      COND_LS: return !fc || fz;
      COND_GE: return fn == fv;
      COND_LT: return fn != fv;
      COND_GT: return !fz && (fn == fv);
      COND_LE: return fz || (fn != fv);
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  state_e            state_q, state_d;
  logic [3:0]        cond_q, opcode_q;
  logic              s_q;
  logic [RD_W-1:0]   rd_q;
  logic [DATA_W-1:0] op1_q, op2_q;
  alu_sel_e          alu_sel;
  logic [DATA_W-1:0] alu_result;
  logic              alu_n, alu_z, alu_c, alu_v;
  logic              cond_ok, supported, compare, do_wb, do_flags;

  assign req_ready = (state_q == ST_IDLE);
  assign wb_valid  = (state_q == ST_WB);
  assign cond_ok   = cond_pass(cond_q, flags);
  assign supported = op_supported(opcode_q);
  assign compare   = op_compare(opcode_q);
  assign do_wb     = cond_ok && supported && !compare;
  assign do_flags  = cond_ok && supported && (s_q || compare);

  // Opcode to ALU operation; compares reuse their arithmetic/logical counterpart
  always_comb begin
    alu_sel = ALU_AND;
    case (opcode_q)
      OP_AND, OP_TST: alu_sel = ALU_AND;
      OP_EOR, OP_TEQ: alu_sel = ALU_EOR;
      OP_SUB, OP_CMP: alu_sel = ALU_SUB;
      OP_RSB:         alu_sel = ALU_RSB;
      OP_ADD, OP_CMN: alu_sel = ALU_ADD;
      OP_ORR:         alu_sel = ALU_ORR;
      OP_BIC:         alu_sel = ALU_BIC;
      default:        alu_sel = ALU_AND;
    endcase
  end

  arm_alu u_alu (
    .a      (op1_q),
    .b      (op2_q),
    .sel    (alu_sel),
    .result (alu_result),
    .n      (alu_n),
    .z      (alu_z),
    .c      (alu_c),
    .v      (alu_v)
  );

  // Next state and retire qualification; a reset cycle never retires
  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    retire_skip  = 1'b0;
    retire_undef = 1'b0;
    case (state_q)
      ST_IDLE: if (req_valid) state_d = ST_EXEC;
      ST_EXEC: begin
        if (do_wb) begin
          state_d = ST_WB;
        end else begin
          state_d      = ST_IDLE;
          retire       = 1'b1;
          retire_undef = !supported;
          retire_skip  = supported && !cond_ok;
        end
      end
      ST_WB: begin
        if (wb_ready) begin
          state_d = ST_IDLE;
          retire  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (reset) begin
      retire       = 1'b0;
      retire_skip  = 1'b0;
      retire_undef = 1'b0;
    end
  end

  // State, request latch, writeback and flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cond_q   <= '0;
      opcode_q <= '0;
      s_q      <= 1'b0;
      rd_q     <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      wb_rd    <= '0;
      wb_data  <= '0;
      flags    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req_valid) begin
        cond_q   <= req_cond;
        opcode_q <= req_opcode;
        s_q      <= req_s;
        rd_q     <= req_rd;
        op1_q    <= req_op1;
        op2_q    <= req_op2;
      end
      if (state_q == ST_EXEC) begin
        if (do_wb) begin
          wb_rd   <= rd_q;
          wb_data <= alu_result;
        end
        if (do_flags) begin
          flags[FLAG_N] <= alu_n;
          flags[FLAG_Z] <= alu_z;
          if (op_arith(opcode_q)) begin
            flags[FLAG_C] <= alu_c;
            flags[FLAG_V] <= alu_v;
          end
        end
      end
    end
  end

endmodule
